// File: rtl/mips_regfile_wb_arbiter_if.sv
// Writeback request bundle for the register-file arbiter.
// Port 0 carries ALU results; port 1 carries load results.
interface mips_regfile_wb_arbiter_if;
  logic        wb0_valid;
  logic [4:0]  wb0_reg;
  logic [31:0] wb0_data;
  logic        wb0_ready;

  logic        wb1_valid;
  logic [4:0]  wb1_reg;
  logic [31:0] wb1_data;
  logic        wb1_ready;

  // Producer side: the ALU / load pipeline stages.
  modport master (
    output wb0_valid, wb0_reg, wb0_data,
    input  wb0_ready,
    output wb1_valid, wb1_reg, wb1_data,
    input  wb1_ready
  );

  // Consumer side: the arbiter.
  modport slave (
    input  wb0_valid, wb0_reg, wb0_data,
    output wb0_ready,
    input  wb1_valid, wb1_reg, wb1_data,
    output wb1_ready
  );
endinterface

// File: rtl/mips_regfile_wb_arbiter.sv
// Two-port writeback arbiter in front of a single register-file write port.
// Each port owns a one-entry buffer; the oldest buffered entry is issued
// each cycle onto a registered write port. When both ports are accepted on
// the same edge, port 0 (ALU) issues first so the load result lands last.
module mips_regfile_wb_arbiter #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_regfile_wb_arbiter_if.slave    wb,
  input  logic                        flush,
  output logic                        rf_write_enable,
  output logic [4:0]                  rf_write_reg,
  output logic [31:0]                 rf_write_data,
  output logic [31:0]                 pending_mask,
  output logic [STALL_CNT_W-1:0]      stall_cnt0,
  output logic [STALL_CNT_W-1:0]      stall_cnt1,
  output logic                        busy
);

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // One-hot decode of a register index, gated by an enable.
  function automatic logic [31:0] reg_onehot(input logic [REG_W-1:0] r, input logic en);
    logic [31:0] oh;
    oh = '0;
    if (en) oh[r] = 1'b1;
    return oh;
  endfunction

  // Stage p0: per-port holding buffers. The age bit marks an entry that
  // arrived while the other buffer already held an older entry.
  logic              buf0_vld_p0, buf1_vld_p0;
  logic [REG_W-1:0]  buf0_reg_p0, buf1_reg_p0;
  logic [DATA_W-1:0] buf0_data_p0, buf1_data_p0;
  logic              buf0_age_p0, buf1_age_p0;

  // Stage p1: registered register-file write port.
  logic              rf_vld_p1;
  logic [REG_W-1:0]  rf_reg_p1;
  logic [DATA_W-1:0] rf_data_p1;

  logic              issue0, issue1, any_issue;
  logic              rdy0, rdy1;
  logic              acc0, acc1;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;

  // Pick the oldest valid buffer; a flush suppresses issue entirely.
  always_comb begin
    issue0    = 1'b0;
    issue1    = 1'b0;
    sel_reg   = buf0_reg_p0;
    sel_data  = buf0_data_p0;
    if (!flush) begin
      issue0 = buf0_vld_p0 && !(buf1_vld_p0 && buf0_age_p0);
      issue1 = buf1_vld_p0 && !issue0;
    end
    if (issue1) begin
      sel_reg  = buf1_reg_p0;
      sel_data = buf1_data_p0;
    end
    any_issue = issue0 || issue1;
  end

  // Ready comes from buffer state only (plus reset/flush), never from valid.
  always_comb begin
    rdy0 = !reset && !flush && (!buf0_vld_p0 || issue0);
    rdy1 = !reset && !flush && (!buf1_vld_p0 || issue1);
    acc0 = wb.wb0_valid && rdy0;
    acc1 = wb.wb1_valid && rdy1;
  end

  assign wb.wb0_ready = rdy0;
  assign wb.wb1_ready = rdy1;

  // Buffer 0 control: load on accept, drop on issue or flush, track age.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      buf0_vld_p0 <= 1'b0;
      buf0_age_p0 <= 1'b0;
    end else if (acc0) begin
      buf0_vld_p0 <= 1'b1;
      buf0_age_p0 <= buf1_vld_p0 && !issue1;
    end else if (issue0) begin
      buf0_vld_p0 <= 1'b0;
      buf0_age_p0 <= 1'b0;
    end else if (issue1) begin
      buf0_age_p0 <= 1'b0;
    end
  end

  // Buffer 1 control: mirror of buffer 0 with the roles swapped.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      buf1_vld_p0 <= 1'b0;
      buf1_age_p0 <= 1'b0;
    end else if (acc1) begin
      buf1_vld_p0 <= 1'b1;
      buf1_age_p0 <= buf0_vld_p0 && !issue0;
    end else if (issue1) begin
      buf1_vld_p0 <= 1'b0;
      buf1_age_p0 <= 1'b0;
    end else if (issue0) begin
      buf1_age_p0 <= 1'b0;
    end
  end

  // Buffer payloads: captured on accept only, no reset needed.
  always_ff @(posedge clk) begin
    if (acc0) begin
      buf0_reg_p0  <= wb.wb0_reg;
      buf0_data_p0 <= wb.wb0_data;
    end
    if (acc1) begin
      buf1_reg_p0  <= wb.wb1_reg;
      buf1_data_p0 <= wb.wb1_data;
    end
  end

  // Write port: one-cycle enable per issue; register 0 is consumed silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_vld_p1  <= 1'b0;
      rf_reg_p1  <= '0;
      rf_data_p1 <= '0;
    end else if (any_issue) begin
      rf_vld_p1  <= |sel_reg;
      rf_reg_p1  <= sel_reg;
      rf_data_p1 <= sel_data;
    end else begin
      rf_vld_p1  <= 1'b0;
    end
  end

  assign rf_write_enable = rf_vld_p1;
  assign rf_write_reg    = rf_reg_p1;
  assign rf_write_data   = rf_data_p1;

  // Per-port stall counters: count cycles a request waits, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt0 <= '0;
      stall_cnt1 <= '0;
    end else begin
      if (wb.wb0_valid && !rdy0) stall_cnt0 <= sat_inc(stall_cnt0);
      if (wb.wb1_valid && !rdy1) stall_cnt1 <= sat_inc(stall_cnt1);
    end
  end

  // Scoreboard view for hazard logic; register 0 never reports pending.
  always_comb begin
    pending_mask = reg_onehot(buf0_reg_p0, buf0_vld_p0)
                 | reg_onehot(buf1_reg_p0, buf1_vld_p0)
                 | reg_onehot(rf_reg_p1, rf_vld_p1);
    pending_mask[0] = 1'b0;
  end

  assign busy = buf0_vld_p0 || buf1_vld_p0 || rf_vld_p1;

endmodule

// File: tb/tb_mips_regfile_wb_arbiter.sv
// Bench for mips_regfile_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_mips_regfile_wb_arbiter;
  localparam int SCW     = 4;
  localparam int SAT_MAX = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic           rf_write_enable;
  logic [4:0]     rf_write_reg;
  logic [31:0]    rf_write_data;
  logic [31:0]    pending_mask;
  logic [SCW-1:0] stall_cnt0, stall_cnt1;
  logic           busy;

  mips_regfile_wb_arbiter_if wb();

  mips_regfile_wb_arbiter #(.STALL_CNT_W(SCW)) dut (
    .clk             (clk),
    .reset           (reset),
    .wb              (wb),
    .flush           (flush),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data),
    .pending_mask    (pending_mask),
    .stall_cnt0      (stall_cnt0),
    .stall_cnt1      (stall_cnt1),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Register file image built from what the DUT actually writes.
  logic [31:0] dut_rf [32];
  always @(posedge clk) if (rf_write_enable) dut_rf[rf_write_reg] <= rf_write_data;

  // Model: accepted entries in arrival order (port 0 before port 1 on a tie);
  // the head of the queue is written each cycle.
  typedef struct {
    int          port;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_reg  = '0;
  logic [31:0] m_data = '0;
  int          m_st0  = 0;
  int          m_st1  = 0;

  // A port can take a request if it has nothing queued, or its entry leaves now.
  function automatic bit m_ready(input int p);
    if (reset || flush) return 1'b0;
    foreach (q[i]) if (q[i].port == p) return (i == 0);
    return 1'b1;
  endfunction

  initial begin : model_and_compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic [31:0] pm;
        pm = '0;
        foreach (q[i]) pm[q[i].r] = 1'b1;
        if (m_we) pm[m_reg] = 1'b1;
        pm[0] = 1'b0;
        chk("ready0", wb.wb0_ready, m_ready(0));
        chk("ready1", wb.wb1_ready, m_ready(1));
        chk("rf_we", rf_write_enable, m_we);
        chk("rf_reg", rf_write_reg, m_reg);
        chk("rf_data", rf_write_data, m_data);
        chk("pending", pending_mask, pm);
        chk("busy", busy, (q.size() != 0) || m_we);
        chk("stall0", stall_cnt0, m_st0);
        chk("stall1", stall_cnt1, m_st1);
      end
      @(posedge clk);
      begin
        bit r0, r1;
        ent_t e;
        r0 = m_ready(0);
        r1 = m_ready(1);
        if (reset) begin
          q.delete();
          m_we = 1'b0; m_reg = '0; m_data = '0; m_st0 = 0; m_st1 = 0;
        end else begin
          if (wb.wb0_valid && !r0 && m_st0 < SAT_MAX) m_st0++;
          if (wb.wb1_valid && !r1 && m_st1 < SAT_MAX) m_st1++;
          if (flush) begin
            q.delete();
            m_we = 1'b0;
          end else begin
            if (q.size() > 0) begin
              e = q.pop_front();
              m_we = (e.r != 0); m_reg = e.r; m_data = e.d;
            end else begin
              m_we = 1'b0;
            end
            if (wb.wb0_valid && r0) begin
              e.port = 0; e.r = wb.wb0_reg; e.d = wb.wb0_data; q.push_back(e);
            end
            if (wb.wb1_valid && r1) begin
              e.port = 1; e.r = wb.wb1_reg; e.d = wb.wb1_data; q.push_back(e);
            end
          end
        end
      end
    end
  end

  task automatic step(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                      input bit fl, input bit rs);
    @(posedge clk);
    #1;
    wb.wb0_valid = v0; wb.wb0_reg = r0; wb.wb0_data = d0;
    wb.wb1_valid = v1; wb.wb1_reg = r1; wb.wb1_data = d1;
    flush = fl;
    reset = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin : stimulus
    wb.wb0_valid = 1'b0; wb.wb0_reg = '0; wb.wb0_data = '0;
    wb.wb1_valid = 1'b0; wb.wb1_reg = '0; wb.wb1_data = '0;

    // Reset: ready held low while reset is asserted.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("rst_ready0", wb.wb0_ready, 1'b0);
    chk("rst_ready1", wb.wb1_ready, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("rst_we", rf_write_enable, 1'b0);
    chk("rst_pending", pending_mask, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk_en = 1'b1;
    idle();
    chk("post_rst_ready0", wb.wb0_ready, 1'b1);
    chk("post_rst_ready1", wb.wb1_ready, 1'b1);

    // Single write: reg 5 from the ALU port.
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle();
    chk("single_pend_a", pending_mask, 32'h20);
    chk("single_we_a", rf_write_enable, 1'b0);
    idle();
    chk("single_we", rf_write_enable, 1'b1);
    chk("single_reg", rf_write_reg, 5'd5);
    chk("single_data", rf_write_data, 32'h1234);
    chk("single_pend_b", pending_mask, 32'h20);
    idle();
    chk("single_we_off", rf_write_enable, 1'b0);
    chk("single_pend_c", pending_mask, 32'h0);

    // Same-edge collision on reg 8: ALU first, load last.
    step(1'b1, 5'd8, 32'hA, 1'b1, 5'd8, 32'hB, 1'b0, 1'b0);
    idle();
    chk("coll_pend", pending_mask, 32'h100);
    chk("coll_ready1", wb.wb1_ready, 1'b0);
    idle();
    chk("coll_first_we", rf_write_enable, 1'b1);
    chk("coll_first", rf_write_data, 32'hA);
    idle();
    chk("coll_second_we", rf_write_enable, 1'b1);
    chk("coll_second", rf_write_data, 32'hB);
    idle();
    chk("coll_final_r8", dut_rf[8], 32'hB);
    chk("coll_we_off", rf_write_enable, 1'b0);

    // Register 0 write: consumed, never enabled, never pending.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0);
    idle();
    chk("r0_busy", busy, 1'b1);
    chk("r0_pend", pending_mask, 32'h0);
    chk("r0_we", rf_write_enable, 1'b0);
    idle();
    chk("r0_busy_off", busy, 1'b0);
    chk("r0_we_off", rf_write_enable, 1'b0);

    // Sustained dual traffic for 10 cycles: port 1 stalls 5 times, port 0 4 times.
    for (int i = 0; i < 10; i++)
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 1'b0);
    idle();
    chk("sust_stall0", stall_cnt0, 4'd4);
    chk("sust_stall1", stall_cnt1, 4'd5);
    for (int i = 0; i < 4; i++) idle();

    // Flush with both buffers full and reg 3 already on the write port.
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
    step(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("fl_ready0", wb.wb0_ready, 1'b0);
    chk("fl_ready1", wb.wb1_ready, 1'b0);
    chk("fl_we", rf_write_enable, 1'b1);
    chk("fl_reg", rf_write_reg, 5'd3);
    chk("fl_pend", pending_mask, 32'h58);
    idle();
    chk("fl_we_after", rf_write_enable, 1'b0);
    chk("fl_pend_after", pending_mask, 32'h0);
    chk("fl_busy_after", busy, 1'b0);
    chk("fl_r3_done", dut_rf[3], 32'h33);

    // Saturation: port 0 held stalled by flush for 20 cycles.
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'd9, $urandom, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle();
    chk("sat_stall0", stall_cnt0, 4'd15);
    chk("sat_stall1", stall_cnt1, 4'd5);

    // Reset in the middle of traffic.
    step(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, 1'b0, 1'b0);
    step(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, 1'b0, 1'b0);
    step(1'b1, 5'd14, 32'h14, 1'b1, 5'd15, 32'h15, 1'b0, 1'b1);
    chk("mid_rst_ready0", wb.wb0_ready, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("mid_rst_we", rf_write_enable, 1'b0);
    chk("mid_rst_reg", rf_write_reg, 5'd0);
    chk("mid_rst_data", rf_write_data, 32'd0);
    chk("mid_rst_pend", pending_mask, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_stall0", stall_cnt0, 4'd0);
    chk("mid_rst_stall1", stall_cnt1, 4'd0);
    idle();
    chk("mid_rst_no_pulse", rf_write_enable, 1'b0);
    chk("mid_rst_ready_back", wb.wb0_ready, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      bit v0, v1, fl, rs;
      v0 = ($urandom_range(0, 99) < 70);
      v1 = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 199) < 1);
      step(v0, 5'($urandom_range(0, 7)), $urandom, v1, 5'($urandom_range(0, 7)), $urandom, fl, rs);
    end
    for (int i = 0; i < 4; i++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_regfile_wb_arbiter.md
MIPS_REGFILE_WB_ARBITER -- requirements
Module: mips_regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of each per-port stall counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports wb0_valid / wb1_valid  input  1  writeback request valid; port 0 = ALU, port 1 = load.
REQ-005 SHALL have ports wb0_reg / wb1_reg  input  5  destination register index.
REQ-006 SHALL have ports wb0_data / wb1_data  input  32  writeback data.
REQ-007 SHALL have ports wb0_ready / wb1_ready  output  1  request accepted this cycle when valid && ready.
REQ-008 SHALL have port flush  input  1  discard all buffered, not-yet-issued requests.
REQ-009 SHALL have ports rf_write_enable  output  1, rf_write_reg  output  5, rf_write_data  output  32  drive the register file write port.
REQ-010 SHALL have port pending_mask  output  32  bit r set while a write to register r is buffered or on the rf_* outputs.
REQ-011 SHALL have ports stall_cnt0 / stall_cnt1  output  STALL_CNT_W  cycles with valid && !ready, per port.
REQ-012 SHALL have port busy  output  1  high when any buffer is valid or rf_write_enable is high.

Function
REQ-013 Each port SHALL own a one-entry buffer (valid, reg, data, age bit).
REQ-014 wbN_ready SHALL be high when bufN is empty or bufN issues this cycle; ready SHALL depend only on registered state, with no combinational path from wbN_valid.
REQ-015 Accept: on a clock edge with wbN_valid && wbN_ready && !flush, bufN SHALL load reg/data and set valid.
REQ-016 Issue selection, once per cycle: only one valid buffer -> issue it; both valid -> issue the older (earlier accept); both accepted the same edge -> issue port 0 first, so port 1 (load) wins on a same-register collision.
REQ-017 Issue SHALL register the selected entry onto rf_write_reg/rf_write_data and set rf_write_enable for exactly one cycle; with no issue, rf_write_enable SHALL be 0 next cycle and reg/data SHALL hold.
REQ-018 An issued entry with reg == 0 SHALL be consumed but SHALL drive rf_write_enable = 0.
REQ-019 Latency: request accepted at edge N -> rf_write_enable high after edge N+1 at the earliest -> register file updated at edge N+2.
REQ-020 Throughput: one issue per cycle; sustained dual-port traffic SHALL alternate without bubbles, and each port's ready SHALL be low on at most every other cycle.
REQ-021 Age bit: set when the entry is accepted while the other buffer holds an older entry; cleared when the other buffer issues.
REQ-022 flush SHALL clear both buffer valids at that edge, block accepts that edge, and force ready low that cycle; an entry already on the rf_* outputs SHALL still complete.
REQ-023 pending_mask SHALL be the OR of the one-hot decodes of buf0.reg, buf1.reg (if valid) and rf_write_reg (if rf_write_enable); bit 0 SHALL always be 0.
REQ-024 stall_cntN SHALL increment on each cycle with wbN_valid && !wbN_ready, saturate at all-ones, and never wrap.
REQ-025 Simultaneous issue from bufN and new accept into bufN SHALL be allowed at the same edge, without a lost or duplicated entry.

Reset
REQ-026 On reset, both buffers SHALL be invalid, age bits 0, and rf_write_enable 0, rf_write_reg 0, rf_write_data 0.
REQ-027 On reset, stall counters SHALL be 0, pending_mask 0 and busy 0; wbN_ready SHALL be 0 during the reset cycle and 1 in the first cycle after.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight writes, with no rf_write_enable pulse afterwards.

Verification
REQ-029 Single write: wb0 reg=5 data=0x1234 accepted at edge N -> rf_write_enable=1, rf_write_reg=5, rf_write_data=0x1234 for one cycle after N+1; pending_mask=0x20 from N to N+2.
REQ-030 Same-edge collision: wb0 reg=8 data=0xA and wb1 reg=8 data=0xB accepted together -> issue 0xA, then 0xB on consecutive cycles; final register 8 value = 0xB.
REQ-031 Sustained traffic: both valid for 10 cycles -> 10 issues alternating 0,1,...; wb0_ready and wb1_ready each low on alternate cycles; stall_cnt0 and stall_cnt1 increment accordingly.
REQ-032 Register 0: wb1 reg=0 data=0xFFFF -> accepted, rf_write_enable stays 0, pending_mask stays 0, busy high one cycle.
REQ-033 Flush: both buffers full, flush=1 -> both valids cleared, no issue from them, pending_mask clears except an rf_* entry already issued, ready low that cycle.
REQ-034 Saturation and reset: STALL_CNT_W=4, wb0 held stalled for 20 cycles -> stall_cnt0=15; reset asserted mid-stream -> all outputs 0 next cycle.
